reg_bank_writeback: RTL and testbench

Register bank with integrated write-destination decode for the multicycle MIPS datapath. Receives the 3-bit RegDest select and the instruction register fields, resolves the destination register number (rt, rd, $ra, $sp, rs), and performs the synchronous write-back. Also provides two combinational read ports with same-cycle bypass, and a sticky flag for illegal RegDest codes. Sits between the control unit / instruction register and the ALU operand latches.

---
 rtl/regbank_pkg.sv | 18 +
 rtl/reg_dest_decode.sv | 27 ++
 rtl/reg_bank_writeback.sv | 84 ++++++++
 tb/tb_reg_bank_writeback.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared constants for the register bank and destination decode
package regbank_pkg;

  // Default register width
  localparam int DATA_W_DEF = 32;

  // reg_dest select codes from the control unit
  localparam logic [2:0] RD_RT = 3'b000;
  localparam logic [2:0] RD_RD = 3'b001;
  localparam logic [2:0] RD_RA = 3'b010;
  localparam logic [2:0] RD_SP = 3'b011;
  localparam logic [2:0] RD_RS = 3'b100;

  // Architectural register numbers with fixed roles
  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_SP = 5'd29;

endpackage

// File: rtl/reg_dest_decode.sv
// rtl/reg_dest_decode.sv - resolves reg_dest into a destination register number
module reg_dest_decode
  import regbank_pkg::*;
(
  input  logic [2:0] reg_dest,
  input  logic [4:0] instr_rt,
  input  logic [4:0] instr_rd,
  input  logic [4:0] instr_rs,
  output logic [4:0] write_addr,
  output logic       dest_legal
);

  // Illegal codes decode to $zero so any downstream write becomes harmless
  always_comb begin
    write_addr = 5'd0;
    dest_legal = 1'b1;
    case (reg_dest)
      RD_RT:   write_addr = instr_rt;
      RD_RD:   write_addr = instr_rd;
      RD_RA:   write_addr = REG_RA;
      RD_SP:   write_addr = REG_SP;
      RD_RS:   write_addr = instr_rs;
      default: dest_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_bank_writeback.sv
// rtl/reg_bank_writeback.sv - 31x register bank with destination decode, bypassed reads, sticky error
module reg_bank_writeback
  import regbank_pkg::*;
#(
  parameter int              DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [2:0]        reg_dest,
  input  logic [4:0]        instr_rt,
  input  logic [4:0]        instr_rd,
  input  logic [4:0]        instr_rs,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [4:0]        write_addr,
  output logic              dest_err
);

  logic              dest_legal;
  logic              wr_en;
  logic              byp_en;
  logic [DATA_W-1:0] regs [31:1];
  logic [DATA_W-1:0] view [0:31];

  reg_dest_decode u_decode (
    .reg_dest   (reg_dest),
    .instr_rt   (instr_rt),
    .instr_rd   (instr_rd),
    .instr_rs   (instr_rs),
    .write_addr (write_addr),
    .dest_legal (dest_legal)
  );

  // A write needs a legal code and a non-zero target; bypass is also held off during reset
  always_comb begin
    wr_en  = reg_write & dest_legal & (write_addr != 5'd0);
    byp_en = wr_en & reset;
  end

  // Register storage: $sp gets its own reset value, $zero has no flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      end
    end else if (wr_en) begin
      for (int i = 1; i < 32; i++) begin
        if (write_addr == 5'(i)) regs[i] <= write_data;
      end
    end
  end

  // Full 32-entry view so read indices never fall outside the array
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      view[i] = regs[i];
    end
  end

  // Read ports with write-through bypass of the value being written this cycle
  always_comb begin
    read_data1 = view[read_reg1];
    read_data2 = view[read_reg2];
    if (byp_en && (read_reg1 == write_addr)) read_data1 = write_data;
    if (byp_en && (read_reg2 == write_addr)) read_data2 = write_data;
  end

  // Sticky flag for attempted writes with an illegal destination code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dest_err <= 1'b0;
    end else if (reg_write && !dest_legal) begin
      dest_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_bank_writeback.sv
// tb/tb_reg_bank_writeback.sv - self-checking bench for reg_bank_writeback
module tb_reg_bank_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write = 1'b0;
  logic [2:0]  reg_dest = 3'd0;
  logic [4:0]  instr_rt = 5'd0;
  logic [4:0]  instr_rd = 5'd0;
  logic [4:0]  instr_rs = 5'd0;
  logic [31:0] write_data = 32'd0;
  logic [4:0]  read_reg1 = 5'd0;
  logic [4:0]  read_reg2 = 5'd0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  write_addr;
  logic        dest_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic [31:0] m_regs [32];
  logic        m_err;

  reg_bank_writeback dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .reg_dest   (reg_dest),
    .instr_rt   (instr_rt),
    .instr_rd   (instr_rd),
    .instr_rs   (instr_rs),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_addr (write_addr),
    .dest_err   (dest_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Destination register number for a code, or -1 when the code is illegal
  function automatic int m_dest(input logic [2:0] c, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] rs);
    case (c)
      3'd0: return int'(rt);
      3'd1: return int'(rd);
      3'd2: return 31;
      3'd3: return 29;
      3'd4: return int'(rs);
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    int d;
    d = m_dest(reg_dest, instr_rt, instr_rd, instr_rs);
    if (reset === 1'b1 && reg_write && d > 0 && int'(a) == d) return write_data;
    if (a == 5'd0) return 32'd0;
    return m_regs[a];
  endfunction

  // Reference model of the architectural state
  always @(posedge clk or negedge reset) begin
    int d;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_regs[29] <= 32'd227;
      m_err <= 1'b0;
    end else begin
      d = m_dest(reg_dest, instr_rt, instr_rd, instr_rs);
      if (reg_write && d > 0) m_regs[d] <= write_data;
      if (reg_write && d < 0) m_err <= 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    int d;
    if (chk_en) begin
      d = m_dest(reg_dest, instr_rt, instr_rd, instr_rs);
      chk("cyc_rd1", read_data1, m_read(read_reg1));
      chk("cyc_rd2", read_data2, m_read(read_reg2));
      chk("cyc_waddr", {27'd0, write_addr}, (d < 0) ? 32'd0 : 32'(d));
      chk("cyc_err", {31'd0, dest_err}, {31'd0, m_err});
    end
  end

  task automatic step(input logic we, input logic [2:0] dst, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] rs, input logic [31:0] data,
                      input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    reg_write  = we;
    reg_dest   = dst;
    instr_rt   = rt;
    instr_rd   = rd;
    instr_rs   = rs;
    write_data = data;
    read_reg1  = r1;
    read_reg2  = r2;
    #2;
  endtask

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    read_reg1 = 5'd29;
    read_reg2 = 5'd31;
    #1;
    chk("rst_sp", read_data1, 32'd227);
    chk("rst_ra", read_data2, 32'd0);
    chk("rst_err", {31'd0, dest_err}, 32'd0);
    chk_en = 1'b1;

    // Write attempted while reset is held: ignored, no bypass
    step(1'b1, 3'd1, 5'd0, 5'd5, 5'd0, 32'h55, 5'd5, 5'd29);
    chk("rst_nobyp", read_data1, 32'd0);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, 5'd5, 5'd29);
    reset = 1'b1;

    // rd destination with same-cycle bypass, then array readback
    step(1'b1, 3'd1, 5'd0, 5'd8, 5'd0, 32'hDEADBEEF, 5'd8, 5'd0);
    chk("rd_bypass", read_data1, 32'hDEADBEEF);
    chk("rd_waddr", {27'd0, write_addr}, 32'd8);
    step(1'b0, 3'd1, 5'd0, 5'd8, 5'd0, 32'h0, 5'd8, 5'd5);
    chk("rd_array", read_data1, 32'hDEADBEEF);
    chk("pre_rst_write", read_data2, 32'd0);

    // $ra then $sp
    step(1'b1, 3'd2, 5'd0, 5'd0, 5'd0, 32'h00400010, 5'd31, 5'd0);
    chk("ra_bypass", read_data1, 32'h00400010);
    step(1'b1, 3'd3, 5'd0, 5'd0, 5'd0, 32'h100, 5'd31, 5'd29);
    chk("ra_array", read_data1, 32'h00400010);
    chk("sp_bypass", read_data2, 32'h100);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, 5'd29, 5'd31);
    chk("sp_array", read_data1, 32'h100);
    chk("ra_kept", read_data2, 32'h00400010);

    // $zero target is a silent no-op
    step(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 32'd5, 5'd0, 5'd0);
    chk("zero_byp", read_data1, 32'd0);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("zero_rd", read_data1, 32'd0);
    chk("zero_err", {31'd0, dest_err}, 32'd0);

    // Illegal code without reg_write does not set the flag
    step(1'b0, 3'd7, 5'd3, 5'd0, 5'd0, 32'd7, 5'd3, 5'd0);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 5'd3, 5'd0);
    chk("ill_nowe_err", {31'd0, dest_err}, 32'd0);

    // rs destination, both ports reading the same register
    step(1'b1, 3'd4, 5'd0, 5'd0, 5'd12, 32'h00C0FFEE, 5'd12, 5'd12);
    chk("rs_byp1", read_data1, 32'h00C0FFEE);
    chk("rs_byp2", read_data2, 32'h00C0FFEE);

    // Illegal code with reg_write: nothing written, flag sets and sticks
    step(1'b1, 3'd6, 5'd3, 5'd0, 5'd0, 32'd7, 5'd3, 5'd0);
    chk("ill_waddr", {27'd0, write_addr}, 32'd0);
    chk("ill_nobyp", read_data1, 32'd0);
    chk("ill_err_pre", {31'd0, dest_err}, 32'd0);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 5'd3, 5'd12);
    chk("ill_reg3", read_data1, 32'd0);
    chk("ill_err_set", {31'd0, dest_err}, 32'd1);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 5'd3, 5'd12);
    chk("ill_err_stick", {31'd0, dest_err}, 32'd1);

    // Back-to-back writes to the same register
    step(1'b1, 3'd1, 5'd0, 5'd4, 5'd0, 32'd1, 5'd4, 5'd0);
    step(1'b1, 3'd1, 5'd0, 5'd4, 5'd0, 32'd9, 5'd4, 5'd0);
    step(1'b0, 3'd1, 5'd0, 5'd4, 5'd0, 32'd0, 5'd4, 5'd0);
    chk("b2b_last", read_data1, 32'd9);

    // Asynchronous reset mid-cycle while a write is pending
    step(1'b1, 3'd1, 5'd0, 5'd4, 5'd0, 32'h77, 5'd4, 5'd29);
    chk("mid_byp", read_data1, 32'h77);
    reset = 1'b0;
    #1;
    chk("mid_rst_r4", read_data1, 32'd0);
    chk("mid_rst_sp", read_data2, 32'd227);
    chk("mid_rst_err", {31'd0, dest_err}, 32'd0);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 5'd4, 5'd31);
    reset = 1'b1;
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 5'd4, 5'd31);
    chk("post_rst_r4", read_data1, 32'd0);
    chk("post_rst_ra", read_data2, 32'd0);

    @(posedge clk);
    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
